// File: rtl/libv_deque_pkg.sv
// Shared opcode and port encodings for the deque command interface.
package libv_deque_pkg;

    typedef enum logic [1:0] {
        PushFront = 2'd0,
        PopFront  = 2'd1,
        PushBack  = 2'd2,
        PopBack   = 2'd3
    } cmd_t;

    typedef enum logic {
        PortFront = 1'b0,
        PortBack  = 1'b1
    } port_t;

    function automatic port_t other_port(input port_t p);
        return (p == PortFront) ? PortBack : PortFront;
    endfunction

endpackage

// File: rtl/libv_deque_rsp_slot.sv
// Single-entry valid/ready holding register for captured pop data.
module libv_deque_rsp_slot #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         rdy,
    output logic         vld,
    output logic [W-1:0] data,
    output logic         can_accept
);

    // A new load may overwrite an entry that is being consumed in the same cycle.
    assign can_accept = !vld || rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld  <= 1'b0;
            data <= '0;
        end else if (load) begin
            vld  <= 1'b1;
            data <= load_data;
        end else if (rdy) begin
            vld  <= 1'b0;
        end
    end

endmodule

// File: rtl/libv_deque_cmd_issuer.sv
// Arbitrates FRONT/BACK requesters onto one deque command channel, tracking
// occupancy locally and holding pop data in one response slot per port.
module libv_deque_cmd_issuer
    import libv_deque_pkg::*;
#(
    parameter int unsigned W = 32,
    parameter int unsigned N = 8
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    front_req_vld,
    input  logic                    front_req_pop,
    input  logic [W-1:0]            front_req_data,
    output logic                    front_req_rdy,
    output logic                    front_rsp_vld,
    output logic [W-1:0]            front_rsp_data,
    input  logic                    front_rsp_rdy,

    input  logic                    back_req_vld,
    input  logic                    back_req_pop,
    input  logic [W-1:0]            back_req_data,
    output logic                    back_req_rdy,
    output logic                    back_rsp_vld,
    output logic [W-1:0]            back_rsp_data,
    input  logic                    back_rsp_rdy,

    output logic                    cmd_vld,
    output cmd_t                    cmd_op,
    output logic [W-1:0]            cmd_push_data,
    input  logic [W-1:0]            cmd_pop_data,

    output logic [$clog2(N+1)-1:0]  occ_r,
    output logic                    empty_r,
    output logic                    full_r
);

    localparam int unsigned OW = $clog2(N + 1);

    port_t         rr_r;
    port_t         rr_nxt;
    logic [OW-1:0] occ_nxt;

    logic front_elig;
    logic back_elig;
    logic grant_front;
    logic grant_back;
    logic front_can_accept;
    logic back_can_accept;

    // State registers: round-robin pointer and occupancy with registered flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_r    <= PortFront;
            occ_r   <= '0;
            empty_r <= 1'b1;
            full_r  <= 1'b0;
        end else begin
            rr_r    <= rr_nxt;
            occ_r   <= occ_nxt;
            empty_r <= (occ_nxt == OW'(0));
            full_r  <= (occ_nxt == OW'(N));
        end
    end

    // Eligibility, arbitration, command drive and next occupancy.
    always_comb begin
        front_elig    = 1'b0;
        back_elig     = 1'b0;
        grant_front   = 1'b0;
        grant_back    = 1'b0;
        rr_nxt        = rr_r;
        cmd_vld       = 1'b0;
        cmd_op        = PushFront;
        cmd_push_data = '0;
        occ_nxt       = occ_r;

        // Commands are suppressed while reset is held so the deque sees no strobe.
        if (!rst) begin
            front_elig = front_req_vld &&
                         (front_req_pop ? (!empty_r && front_can_accept) : !full_r);
            back_elig  = back_req_vld &&
                         (back_req_pop ? (!empty_r && back_can_accept) : !full_r);
        end

        if (front_elig && back_elig) begin
            grant_front = (rr_r == PortFront);
            grant_back  = (rr_r == PortBack);
            rr_nxt      = other_port(rr_r);
        end else begin
            grant_front = front_elig;
            grant_back  = back_elig;
        end

        if (grant_front) begin
            cmd_vld       = 1'b1;
            cmd_op        = front_req_pop ? PopFront : PushFront;
            cmd_push_data = front_req_data;
            occ_nxt       = front_req_pop ? (occ_r - OW'(1)) : (occ_r + OW'(1));
        end else if (grant_back) begin
            cmd_vld       = 1'b1;
            cmd_op        = back_req_pop ? PopBack : PushBack;
            cmd_push_data = back_req_data;
            occ_nxt       = back_req_pop ? (occ_r - OW'(1)) : (occ_r + OW'(1));
        end
    end

    assign front_req_rdy = grant_front;
    assign back_req_rdy  = grant_back;

    libv_deque_rsp_slot #(.W(W)) u_front_slot (
        .clk        (clk),
        .rst        (rst),
        .load       (grant_front && front_req_pop),
        .load_data  (cmd_pop_data),
        .rdy        (front_rsp_rdy),
        .vld        (front_rsp_vld),
        .data       (front_rsp_data),
        .can_accept (front_can_accept)
    );

    libv_deque_rsp_slot #(.W(W)) u_back_slot (
        .clk        (clk),
        .rst        (rst),
        .load       (grant_back && back_req_pop),
        .load_data  (cmd_pop_data),
        .rdy        (back_rsp_rdy),
        .vld        (back_rsp_vld),
        .data       (back_rsp_data),
        .can_accept (back_can_accept)
    );

    // Eligibility gating makes overflow unreachable.
    occ_bound_a: assert property (@(posedge clk) disable iff (rst) occ_r <= OW'(N));

endmodule

// File: tb/tb_libv_deque_cmd_issuer.sv
// Randomised scoreboard bench for libv_deque_cmd_issuer with a behavioural deque model.
module tb_libv_deque_cmd_issuer;
    import libv_deque_pkg::*;

    localparam int unsigned W  = 8;
    localparam int unsigned N  = 4;
    localparam int unsigned OW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          front_req_vld = 0, front_req_pop = 0, front_rsp_rdy = 0;
    logic [W-1:0]  front_req_data = '0;
    logic          back_req_vld = 0, back_req_pop = 0, back_rsp_rdy = 0;
    logic [W-1:0]  back_req_data = '0;
    logic          front_req_rdy, front_rsp_vld, back_req_rdy, back_rsp_vld;
    logic [W-1:0]  front_rsp_data, back_rsp_data;
    logic          cmd_vld;
    cmd_t          cmd_op;
    logic [W-1:0]  cmd_push_data, cmd_pop_data;
    logic [OW-1:0] occ_r;
    logic          empty_r, full_r;

    always #5 clk = ~clk;

    libv_deque_cmd_issuer #(.W(W), .N(N)) dut (
        .clk            (clk),
        .rst            (rst),
        .front_req_vld  (front_req_vld),
        .front_req_pop  (front_req_pop),
        .front_req_data (front_req_data),
        .front_req_rdy  (front_req_rdy),
        .front_rsp_vld  (front_rsp_vld),
        .front_rsp_data (front_rsp_data),
        .front_rsp_rdy  (front_rsp_rdy),
        .back_req_vld   (back_req_vld),
        .back_req_pop   (back_req_pop),
        .back_req_data  (back_req_data),
        .back_req_rdy   (back_req_rdy),
        .back_rsp_vld   (back_rsp_vld),
        .back_rsp_data  (back_rsp_data),
        .back_rsp_rdy   (back_rsp_rdy),
        .cmd_vld        (cmd_vld),
        .cmd_op         (cmd_op),
        .cmd_push_data  (cmd_push_data),
        .cmd_pop_data   (cmd_pop_data),
        .occ_r          (occ_r),
        .empty_r        (empty_r),
        .full_r         (full_r)
    );

    // Deque instance stand-in: reacts to the commands the DUT actually issues.
    logic [W-1:0] dmem [N];
    logic [2:0]   dcnt;

    always_comb begin
        cmd_pop_data = '0;
        if (cmd_vld && dcnt != 3'd0) begin
            if (cmd_op == PopFront)     cmd_pop_data = dmem[0];
            else if (cmd_op == PopBack) cmd_pop_data = dmem[dcnt - 3'd1];
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dcnt <= 3'd0;
        end else if (cmd_vld) begin
            case (cmd_op)
                PushFront: if (dcnt < 3'(N)) begin
                    for (int i = N - 1; i > 0; i--) dmem[i] <= dmem[i-1];
                    dmem[0] <= cmd_push_data;
                    dcnt    <= dcnt + 3'd1;
                end
                PopFront: if (dcnt != 3'd0) begin
                    for (int i = 0; i < N - 1; i++) dmem[i] <= dmem[i+1];
                    dcnt <= dcnt - 3'd1;
                end
                PushBack: if (dcnt < 3'(N)) begin
                    dmem[dcnt] <= cmd_push_data;
                    dcnt       <= dcnt + 3'd1;
                end
                default: if (dcnt != 3'd0) dcnt <= dcnt - 3'd1;
            endcase
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
        end
    endtask

    // Reference: deque contents, pending responses per port, round-robin owner.
    logic [W-1:0] ref_q [$];
    logic [W-1:0] exp_f [$];
    logic [W-1:0] exp_b [$];
    bit           rr_back = 1'b0;

    // Monitor: compares presented responses against the scoreboard heads.
    always @(negedge clk) begin
        #1;
        if (rst) begin
            chk("rst_front_rsp_vld", 32'(front_rsp_vld), 32'd0);
            chk("rst_back_rsp_vld", 32'(back_rsp_vld), 32'd0);
            exp_f.delete();
            exp_b.delete();
        end else begin
            chk("front_rsp_vld", 32'(front_rsp_vld), 32'(exp_f.size() != 0));
            if (front_rsp_vld && exp_f.size() != 0) begin
                chk("front_rsp_data", 32'(front_rsp_data), 32'(exp_f[0]));
                if (front_rsp_rdy) void'(exp_f.pop_front());
            end
            chk("back_rsp_vld", 32'(back_rsp_vld), 32'(exp_b.size() != 0));
            if (back_rsp_vld && exp_b.size() != 0) begin
                chk("back_rsp_data", 32'(back_rsp_data), 32'(exp_b[0]));
                if (back_rsp_rdy) void'(exp_b.pop_front());
            end
        end
    end

    // Request-side checker: predicts grants and command from the deque rules.
    bit fe, be, gf, gb;
    always @(negedge clk) begin
        #2;
        if (rst) begin
            chk("rst_occ", 32'(occ_r), 32'd0);
            chk("rst_empty", 32'(empty_r), 32'd1);
            chk("rst_full", 32'(full_r), 32'd0);
            chk("rst_cmd_vld", 32'(cmd_vld), 32'd0);
            chk("rst_front_rdy", 32'(front_req_rdy), 32'd0);
            chk("rst_back_rdy", 32'(back_req_rdy), 32'd0);
            ref_q.delete();
            rr_back = 1'b0;
        end else begin
            chk("occ", 32'(occ_r), 32'(ref_q.size()));
            chk("empty", 32'(empty_r), 32'(ref_q.size() == 0));
            chk("full", 32'(full_r), 32'(ref_q.size() == N));
            fe = front_req_vld && (front_req_pop ? (ref_q.size() > 0 && exp_f.size() == 0)
                                                 : (ref_q.size() < N));
            be = back_req_vld && (back_req_pop ? (ref_q.size() > 0 && exp_b.size() == 0)
                                               : (ref_q.size() < N));
            gf = fe && (!be || !rr_back);
            gb = be && (!fe || rr_back);
            if (fe && be) rr_back = !rr_back;
            chk("front_req_rdy", 32'(front_req_rdy), 32'(gf));
            chk("back_req_rdy", 32'(back_req_rdy), 32'(gb));
            chk("cmd_vld", 32'(cmd_vld), 32'(gf || gb));
            if (gf) begin
                chk("cmd_op_front", 32'(cmd_op), front_req_pop ? 32'd1 : 32'd0);
                chk("cmd_push_data", 32'(cmd_push_data), 32'(front_req_data));
                if (front_req_pop) exp_f.push_back(ref_q.pop_front());
                else               ref_q.push_front(front_req_data);
            end else if (gb) begin
                chk("cmd_op_back", 32'(cmd_op), back_req_pop ? 32'd3 : 32'd2);
                chk("cmd_push_data", 32'(cmd_push_data), 32'(back_req_data));
                if (back_req_pop) exp_b.push_back(ref_q.pop_back());
                else              ref_q.push_back(back_req_data);
            end else begin
                chk("idle_cmd_op", 32'(cmd_op), 32'd0);
                chk("idle_push_data", 32'(cmd_push_data), 32'd0);
            end
        end
    end

    task automatic drive(input logic r,
                         input logic fv, input logic fp, input logic [W-1:0] fd, input logic fr,
                         input logic bv, input logic bp, input logic [W-1:0] bd, input logic br);
        @(negedge clk);
        rst            = r;
        front_req_vld  = fv;
        front_req_pop  = fp;
        front_req_data = fd;
        front_rsp_rdy  = fr;
        back_req_vld   = bv;
        back_req_pop   = bp;
        back_req_data  = bd;
        back_rsp_rdy   = br;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0, 8'h00, 1, 0, 0, 8'h00, 1);
    endtask

    task automatic drain;
        repeat (N + 2) drive(0, 1, 1, 8'h00, 1, 1, 1, 8'h00, 1);
        idle(2);
    endtask

    initial begin
        drive(1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0);
        drive(1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0);
        idle(1);

        // Push 0x11, 0x22 at FRONT, then PopFront returns 0x22.
        drive(0, 1, 0, 8'h11, 1, 0, 0, 8'h00, 1);
        drive(0, 1, 0, 8'h22, 1, 0, 0, 8'h00, 1);
        drive(0, 1, 1, 8'h00, 1, 0, 0, 8'h00, 1);
        idle(2);
        drain();

        // Fill from BACK, pushes blocked at full, PopBack still granted.
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 8'h00, 1, 1, 0, 8'(8'hA0 + i), 1);
        drive(0, 1, 0, 8'h55, 1, 1, 0, 8'h66, 1);
        drive(0, 1, 0, 8'h77, 1, 0, 0, 8'h00, 1);
        drive(0, 1, 0, 8'h78, 1, 1, 1, 8'h00, 1);
        idle(2);
        drain();

        // Contested pushes from empty alternate until full.
        for (int i = 0; i < 6; i++) drive(0, 1, 0, 8'(8'h30 + i), 1, 1, 0, 8'(8'h40 + i), 1);
        idle(1);

        // FRONT pops with response held, then released.
        for (int i = 0; i < 3; i++) drive(0, 1, 1, 8'h00, 0, 0, 0, 8'h00, 1);
        drive(0, 1, 1, 8'h00, 1, 0, 0, 8'h00, 1);
        drive(0, 1, 1, 8'h00, 1, 0, 0, 8'h00, 1);
        idle(2);
        drain();

        // Single entry, both ports pop.
        drive(0, 1, 0, 8'h99, 1, 0, 0, 8'h00, 1);
        drive(0, 1, 1, 8'h00, 1, 1, 1, 8'h00, 1);
        drive(0, 1, 1, 8'h00, 1, 1, 1, 8'h00, 1);
        idle(2);

        // Reset while a pop response is pending.
        drive(0, 1, 0, 8'h5A, 1, 0, 0, 8'h00, 1);
        drive(0, 0, 0, 8'h00, 1, 1, 0, 8'h5B, 1);
        drive(0, 1, 1, 8'h00, 0, 0, 0, 8'h00, 0);
        drive(1, 1, 1, 8'h00, 0, 1, 0, 8'h5C, 0);
        drive(1, 1, 0, 8'h5D, 0, 1, 0, 8'h5E, 0);
        idle(1);
        drive(0, 1, 0, 8'h61, 1, 1, 0, 8'h62, 1);
        idle(2);

        // Randomised traffic with occasional reset.
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 299) == 0),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  8'($urandom), 1'($urandom_range(0, 9) < 7),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  8'($urandom), 1'($urandom_range(0, 9) < 7));
        end
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
